// File: rtl/fp32_pkg.sv
// Shared FP32 constants, operand classes and divider state encoding.
package fp32_pkg;
   localparam int FP_EXP_W  = 8;
   localparam int FP_FRAC_W = 23;
   localparam int FP_BIAS   = 127;
   localparam int DIV_ITERS = 26;

   localparam logic [31:0] FP_CANON_NAN = 32'hFFC0_0000;
   localparam logic [31:0] FP_POS_INF   = 32'h7F80_0000;

   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_t;
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_ROUND, S_DONE} div_state_t;
endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 unpack: classify the operand and normalize subnormals so
// the mantissa always has bit 23 set, with a signed unbiased exponent.
module fp32_unpack
   import fp32_pkg::*;
(
   input  logic [31:0]        i_x,
   output logic               o_sign,
   output fp_class_t          o_cls,
   output logic signed [9:0]  o_exp,
   output logic [23:0]        o_man
);
   logic [7:0]  w_e;
   logic [22:0] w_f;
   logic [4:0]  w_lz;

   assign w_e = i_x[30:23];
   assign w_f = i_x[22:0];

   // shift needed to move the highest set fraction bit up to bit 23
   always_comb begin
      w_lz = 5'd0;
      for (int i = 0; i < 23; i++)
         if (w_f[i]) w_lz = 5'(23 - i);
   end

   always_comb begin
      o_sign = i_x[31];
      o_cls  = ZERO;
      o_exp  = 10'sd0;
      o_man  = 24'd0;
      if (w_e == 8'hFF) begin
         o_cls = (w_f != 23'd0) ? NAN : INF;
      end else if (w_e == 8'd0) begin
         if (w_f != 23'd0) begin
            o_cls = SUB;
            o_man = {1'b0, w_f} << w_lz;
            o_exp = -10'sd126 - $signed({5'd0, w_lz});
         end
      end else begin
         o_cls = NORM;
         o_man = {1'b1, w_f};
         o_exp = $signed({2'b00, w_e}) - 10'sd127;
      end
   end
endmodule

// File: rtl/fp32_div_seq.sv
// Iterative FP32 divider: restoring radix-2 recurrence, one quotient bit per
// clock, RNE rounding with subnormal results, valid/ready on both sides.
module fp32_div_seq
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        div_by_zero,
   output logic        invalid
);
   div_state_t r_state, w_next;

   logic [31:0]       r_a, r_b, r_result;
   logic              r_dbz, r_inv, r_sign;
   logic signed [9:0] r_ze;
   logic [24:0]       r_rem;
   logic [23:0]       r_mb;
   logic [25:0]       r_q;
   logic [4:0]        r_cnt;

   logic              w_sa, w_sb;
   fp_class_t         w_ca, w_cb;
   logic signed [9:0] w_ea, w_eb, w_ze0;
   logic [23:0]       w_ma, w_mb;

   fp32_unpack u_unpack_a (.i_x(r_a), .o_sign(w_sa), .o_cls(w_ca), .o_exp(w_ea), .o_man(w_ma));
   fp32_unpack u_unpack_b (.i_x(r_b), .o_sign(w_sb), .o_cls(w_cb), .o_exp(w_eb), .o_man(w_mb));

   assign w_ze0 = w_ea - w_eb + 10'sd127;

   // special-operand short cut; inf/0 is treated as inf/finite, not div-by-zero
   logic        w_special, w_spec_dbz, w_spec_inv, w_sign;
   logic [31:0] w_spec_res;
   assign w_sign = w_sa ^ w_sb;

   always_comb begin
      w_special  = 1'b1;
      w_spec_dbz = 1'b0;
      w_spec_inv = 1'b0;
      w_spec_res = FP_CANON_NAN;
      if (w_ca == NAN || w_cb == NAN) begin
         w_spec_res = FP_CANON_NAN;
      end else if ((w_ca == ZERO && w_cb == ZERO) || (w_ca == INF && w_cb == INF)) begin
         w_spec_inv = 1'b1;
      end else if (w_ca == INF) begin
         w_spec_res = {w_sign, FP_POS_INF[30:0]};
      end else if (w_cb == ZERO) begin
         w_spec_res = {w_sign, FP_POS_INF[30:0]};
         w_spec_dbz = 1'b1;
      end else if (w_ca == ZERO || w_cb == INF) begin
         w_spec_res = {w_sign, 31'd0};
      end else begin
         w_special  = 1'b0;
      end
   end

   // one recurrence step
   logic [24:0] w_diff, w_rem_nx;
   logic        w_ge;
   assign w_diff   = r_rem - {1'b0, r_mb};
   assign w_ge     = (r_rem >= {1'b0, r_mb});
   assign w_rem_nx = w_ge ? w_diff : r_rem;

   // denormalize (if needed), then RNE on guard/round/sticky
   logic [9:0]  w_sh, w_ef;
   logic [4:0]  w_sh_c;
   logic [24:0] w_qs;
   logic [25:0] w_mask;
   logic        w_st, w_inc;
   logic [32:0] w_pack;
   logic [31:0] w_rnd_res;

   always_comb begin
      w_sh   = 10'd0;
      w_sh_c = 5'd0;
      w_qs   = r_q[24:0];
      w_mask = 26'd0;
      w_ef   = $unsigned(r_ze);
      if (r_ze <= 10'sd0) begin
         w_sh   = $unsigned(10'sd1 - r_ze);
         w_sh_c = (w_sh > 10'd26) ? 5'd26 : w_sh[4:0];
         w_qs   = 25'(r_q >> w_sh_c);
         w_mask = 26'((27'd1 << w_sh_c) - 27'd1);
         w_ef   = 10'd0;
      end
      w_st      = (r_rem != 25'd0) | (|(r_q & w_mask));
      w_inc     = w_qs[1] & (w_qs[0] | w_st | w_qs[2]);
      // the carry out of the fraction lands in the exponent field directly
      w_pack    = {w_ef, w_qs[24:2]} + {32'd0, w_inc};
      w_rnd_res = (w_pack[32:23] >= 10'd255) ? {r_sign, FP_POS_INF[30:0]}
                                             : {r_sign, w_pack[30:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = !rst;
            if (in_valid) w_next = S_PREP;
         end
         S_PREP:  w_next = w_special ? S_DONE : S_DIV;
         S_DIV:   if (r_cnt == 5'(DIV_ITERS - 1)) w_next = S_ROUND;
         S_ROUND: w_next = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a <= 32'd0;  r_b <= 32'd0;  r_result <= 32'd0;
         r_dbz <= 1'b0; r_inv <= 1'b0; r_sign <= 1'b0;
         r_ze <= 10'sd0; r_rem <= 25'd0; r_mb <= 24'd0;
         r_q <= 26'd0;  r_cnt <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_a <= a;
               r_b <= b;
            end
            S_PREP: begin
               r_result <= w_spec_res;
               r_dbz    <= w_spec_dbz;
               r_inv    <= w_spec_inv;
               r_sign   <= w_sign;
               r_mb     <= w_mb;
               r_q      <= 26'd0;
               r_cnt    <= 5'd0;
               // keep the quotient in [1,2) so bit 25 is always the leading one
               if (w_ma < w_mb) begin
                  r_rem <= {w_ma, 1'b0};
                  r_ze  <= w_ze0 - 10'sd1;
               end else begin
                  r_rem <= {1'b0, w_ma};
                  r_ze  <= w_ze0;
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nx << 1;
               r_q   <= {r_q[24:0], w_ge};
               r_cnt <= r_cnt + 5'd1;
            end
            S_ROUND: r_result <= w_rnd_res;
            default: ;
         endcase
      end
   end

   assign result      = r_result;
   assign div_by_zero = r_dbz;
   assign invalid     = r_inv;
endmodule

// File: tb/tb_fp32_div_seq.sv
// Scoreboard bench for fp32_div_seq: directed vectors with hand-derived
// results, latency, backpressure and mid-operation reset.
module tb_fp32_div_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        div_by_zero, invalid;

   fp32_div_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .div_by_zero(div_by_zero), .invalid(invalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        dbz;
      logic        inv;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // monitor: compare whenever an output handshake is about to happen
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", result, e.res);
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            check("invalid", {31'd0, invalid}, {31'd0, e.inv});
            if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
         end
      end
   end

   task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] res,
                        input logic dbz, input logic inv, input int lat, input logic push);
      int n;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1; a = va; b = vb;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("accept_timeout", 32'd1, 32'd0);
      e.res = res; e.dbz = dbz; e.inv = inv; e.lat = lat; e.acc = cyc + 1;
      if (push) sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 32'd1, 32'd0);
         sb.delete();
      end
   endtask

   typedef struct {
      logic [31:0] a, b, r;
      logic        dbz, inv;
      int          lat;
   } vec_t;

   vec_t vecs[14] = '{
      '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28},
      '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28},
      '{32'h40000000, 32'h40800000, 32'h3F000000, 1'b0, 1'b0, 28},
      '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 28},
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1},
      '{32'h00000000, 32'h00000000, 32'hFFC00000, 1'b0, 1'b1, 1},
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1},
      '{32'h7F800000, 32'hFF800000, 32'hFFC00000, 1'b0, 1'b1, 1},
      '{32'h7FC00000, 32'h3F800000, 32'hFFC00000, 1'b0, 1'b0, 1},
      '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1},
      '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1},
      '{32'h00800000, 32'h40000000, 32'h00400000, 1'b0, 1'b0, 28},
      '{32'h00000001, 32'h3F000000, 32'h00000002, 1'b0, 1'b0, 28},
      '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 28}
   };

   initial begin
      int n;
      logic seen;

      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {30'd0, div_by_zero, invalid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("idle_in_ready", {31'd0, in_ready}, 32'd1);

      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].dbz, vecs[i].inv, vecs[i].lat, 1'b1);
         drain();
      end

      // backpressure: 1.0/2.0 held in DONE while in_valid toggles
      out_ready = 1'b0;
      issue(32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0, 1'b0, -1, 1'b1);
      n = 0;
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1 in_valid = 1'b1; a = $urandom; b = $urandom;
         @(negedge clk);
         check("bp_result_stable", result, 32'h3F000000);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_idle", {30'd0, out_valid, in_ready}, 32'd1);
      drain();

      // reset pulse mid-division discards the operation
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1 check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_output", {31'd0, seen}, 32'd0);

      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28, 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
